basys3_keypad_scanner: RTL and testbench

//  Input-side counterpart of the 7-seg display driver. Scans a 4x4 Pmod KYPD

---
 rtl/basys3_keypad_scanner.sv | 267 ++++++++++++++++++++++++++
 tb/tb_basys3_keypad_scanner.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/basys3_keypad_scanner.sv
// Scans a 4x4 active-low keypad matrix and debounces the result over whole scans.
// Each accepted press is reported as a hex code with a one-cycle strobe.
// key_valid_o rises one clock after the scan_end of the last qualifying scan.
// There is no backpressure. Each strobe is a single-cycle event, and key_o holds
// the code until the next accept.
//
// Ports:
//   clk_1k_i     1 kHz system clock (single domain)
//   rst_i        synchronous active-high reset
//   row_i[3:0]   keypad rows, active-low, asynchronous to clk_1k_i
//   col_o[3:0]   keypad column drive, active-low, exactly one bit low
//   key_o[3:0]   hex code of the last accepted key
//   key_valid_o  one-cycle pulse per accepted press
//   key_held_o   high while the accepted key is considered pressed
module basys3_keypad_scanner #(
    parameter int DWELL_CYCLES   = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk_1k_i,
    input  logic       rst_i,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic [3:0] key_o,
    output logic       key_valid_o,
    output logic       key_held_o
);

    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    // Snapshot bit index is {row, col}. Map it to the legend printed on the keypad.
    function automatic logic [3:0] key_map(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'h0;
            4'd13:   code = 4'hF;
            4'd14:   code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // ------------------------------------------------------------------
    // Two-flop row synchronizer. It resets to "all rows released".
    // ------------------------------------------------------------------
    logic [3:0] row_meta_q;
    logic [3:0] row_sync_q;

    always_ff @(posedge clk_1k_i) begin
        if (rst_i) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= row_i;
            row_sync_q <= row_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Column scan. Rows are sampled on the last dwell cycle. At that point
    // row_sync_q reflects rows seen two clocks into the dwell. This leaves the
    // synchronizer time to flush the previous column, which is why the dwell
    // must be at least 3 clocks.
    // ------------------------------------------------------------------
    logic [1:0]    col_q, col_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          sample;
    logic          scan_end;

    assign sample   = (dwell_q == DWELL_LAST);
    assign scan_end = sample && (col_q == 2'd3);

    always_comb begin
        dwell_d = dwell_q + DW'(1);
        col_d   = col_q;
        if (sample) begin
            dwell_d = '0;
            col_d   = col_q + 2'd1;
        end
    end

    always_ff @(posedge clk_1k_i) begin
        if (rst_i) begin
            col_q   <= 2'd0;
            dwell_q <= '0;
        end else begin
            col_q   <= col_d;
            dwell_q <= dwell_d;
        end
    end

    assign col_o = ~(4'b0001 << col_q);

    // ------------------------------------------------------------------
    // Snapshot of the pressed keys (active-high), one bit per {row, col}.
    // The scan is classified from snap_d, so that column 3 (sampled on the
    // scan_end cycle itself) is already included.
    // ------------------------------------------------------------------
    logic [15:0] snap_q, snap_d;

    always_comb begin
        snap_d = snap_q;
        if (sample) begin
            for (int r = 0; r < 4; r++) begin
                snap_d[{2'(r), col_q}] = ~row_sync_q[r];
            end
        end
    end

    always_ff @(posedge clk_1k_i) begin
        if (rst_i) begin
            snap_q <= '0;
        end else begin
            snap_q <= snap_d;
        end
    end

    logic [4:0] n_pressed;
    logic [3:0] single_code;
    logic       is_none;
    logic       is_single;

    always_comb begin
        n_pressed   = '0;
        single_code = '0;
        for (int i = 0; i < 16; i++) begin
            if (snap_d[i]) begin
                n_pressed   = n_pressed + 5'd1;
                single_code = key_map(4'(i));
            end
        end
    end

    assign is_none   = (n_pressed == 5'd0);
    assign is_single = (n_pressed == 5'd1);

    // ------------------------------------------------------------------
    // Debounce FSM. It only moves on scan_end. Any scan that is neither NONE
    // nor SINGLE is MULTI.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_CHK,
        ST_HELD,
        ST_REL_CHK
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    key_q, key_d;
    logic          valid_q, valid_d;
    logic          held_q, held_d;

    // The scan counter saturates at the threshold instead of wrapping.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        key_d   = key_q;
        valid_d = 1'b0;
        held_d  = held_q;

        if (scan_end) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (is_single) begin
                        cand_d = single_code;
                        cnt_d  = CNT_ONE;
                        if (cnt_d == CNT_MAX) begin
                            key_d   = single_code;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            state_d = ST_HELD;
                        end else begin
                            state_d = ST_PRESS_CHK;
                        end
                    end
                end

                ST_PRESS_CHK: begin
                    if (is_single && (single_code == cand_q)) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            key_d   = cand_q;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            state_d = ST_HELD;
                        end
                    end else if (is_single) begin
                        // A different key restarts qualification instead of aborting it.
                        cand_d = single_code;
                        cnt_d  = CNT_ONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end

                ST_HELD: begin
                    if (is_none) begin
                        cnt_d = CNT_ONE;
                        if (cnt_d == CNT_MAX) begin
                            held_d  = 1'b0;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_REL_CHK;
                        end
                    end
                end

                ST_REL_CHK: begin
                    if (is_none) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            held_d  = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_HELD;
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_1k_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cand_q  <= 4'h0;
            key_q   <= 4'h0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            key_q   <= key_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    assign key_o       = key_q;
    assign key_valid_o = valid_q;
    assign key_held_o  = held_q;

endmodule

// File: tb/tb_basys3_keypad_scanner.sv
// Bench for basys3_keypad_scanner: a scan-level keypad model drives the rows.
// A run-length debounce model predicts the outputs, and these are compared every cycle.
// Directed scenarios add literal checks on pulse count, timing and codes.
module tb_basys3_keypad_scanner;

    localparam int DWELL = 4;
    localparam int NDEB  = 3;
    localparam int SCAN  = 4 * DWELL;

    localparam logic [15:0] K1 = 16'h0001;
    localparam logic [15:0] KA = 16'h0008;
    localparam logic [15:0] K5 = 16'h0020;
    localparam logic [15:0] K7 = 16'h0100;
    localparam logic [15:0] K8 = 16'h0200;
    localparam logic [15:0] K9 = 16'h0400;
    localparam logic [15:0] KD = 16'h8000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_i;
    logic [3:0] col_o;
    logic [3:0] key_o;
    logic       key_valid_o;
    logic       key_held_o;

    logic [15:0] mask = 16'h0;   // pressed keys, bit {row, col}

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    basys3_keypad_scanner #(
        .DWELL_CYCLES  (DWELL),
        .DEBOUNCE_SCANS(NDEB)
    ) dut (
        .clk_1k_i   (clk),
        .rst_i      (rst),
        .row_i      (row_i),
        .col_o      (col_o),
        .key_o      (key_o),
        .key_valid_o(key_valid_o),
        .key_held_o (key_held_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Physical keypad: a pressed key shorts its row to its column.
    always_comb begin
        row_i = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!col_o[c] && mask[r*4+c]) row_i[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] legend(input int idx);
        logic [3:0] v;
        case (idx)
            0: v = 4'h1;  1: v = 4'h2;  2: v = 4'h3;  3: v = 4'hA;
            4: v = 4'h4;  5: v = 4'h5;  6: v = 4'h6;  7: v = 4'hB;
            8: v = 4'h7;  9: v = 4'h8; 10: v = 4'h9; 11: v = 4'hC;
            12: v = 4'h0; 13: v = 4'hF; 14: v = 4'hE; default: v = 4'hD;
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Reference model. Each scan is classified (0..15 = single key code,
    // 16 = none, 17 = multi). A press is accepted once NDEB identical SINGLE
    // scans are in a row while no key is held. A release occurs once NDEB
    // NONE scans are in a row while a key is held.
    // ------------------------------------------------------------------
    bit          model_ok = 0;
    int          t;
    int          run_cls, run_len;
    logic [15:0] scan_mask;
    logic [3:0]  m_col, m_key;
    logic        m_valid, m_held;

    always @(posedge clk) begin
        if (rst) begin
            t = 0; run_cls = 18; run_len = 0; scan_mask = '0;
            m_key = 4'h0; m_valid = 1'b0; m_held = 1'b0;
            model_ok = 1;
        end else begin
            int cls;
            m_valid = 1'b0;
            if (t % SCAN == SCAN / 2) scan_mask = mask;
            if (t % SCAN == SCAN - 1) begin
                if ($countones(scan_mask) == 0) cls = 16;
                else if ($countones(scan_mask) > 1) cls = 17;
                else begin
                    cls = 0;
                    for (int i = 0; i < 16; i++) if (scan_mask[i]) cls = legend(i);
                end
                if (cls == run_cls) run_len++;
                else begin run_cls = cls; run_len = 1; end
                if (!m_held && cls < 16 && run_len >= NDEB) begin
                    m_key = 4'(cls); m_valid = 1'b1; m_held = 1'b1;
                end else if (m_held && cls == 16 && run_len >= NDEB) begin
                    m_held = 1'b0;
                end
            end
            t++;
        end
        m_col = ~(4'b0001 << ((t / DWELL) % 4));
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("col_o", 32'(col_o), 32'(m_col));
            check("key_o", 32'(key_o), 32'(m_key));
            check("key_valid_o", 32'(key_valid_o), 32'(m_valid));
            check("key_held_o", 32'(key_held_o), 32'(m_held));
        end
    end

    // Pulse monitor, settled just after each rising edge.
    int         pulse_cnt = 0;
    int         last_pulse_cyc = -1;
    logic [3:0] last_pulse_key = 4'h0;
    bit         saw7 = 0;

    always @(posedge clk) begin
        #1;
        if (key_valid_o) begin
            pulse_cnt++;
            last_pulse_cyc = cyc;
            last_pulse_key = key_o;
            if (key_o == 4'h7) saw7 = 1;
        end
    end

    // Leaves the bench at the negedge of the first post-reset cycle.
    task automatic reset_dut();
        rst = 1'b1;
        mask = 16'h0;
        repeat (3) @(negedge clk);
        check("rst col_o", 32'(col_o), 32'h0000_000E);
        check("rst key_o", 32'(key_o), 32'h0);
        check("rst valid", 32'(key_valid_o), 32'h0);
        check("rst held", 32'(key_held_o), 32'h0);
        rst = 1'b0;
    endtask

    // Literal column walk for one scan. It ends on the scan_end cycle.
    task automatic col_walk();
        logic [3:0] lit;
        for (int i = 0; i < SCAN; i++) begin
            lit = (i < 4) ? 4'b1110 : (i < 8) ? 4'b1101 : (i < 12) ? 4'b1011 : 4'b0111;
            check("col walk", 32'(col_o), 32'(lit));
            if (i < SCAN - 1) @(negedge clk);
        end
    endtask

    // Called on the scan_end cycle's negedge. It returns on a later scan_end negedge.
    task automatic run_scans(input logic [15:0] m, input int n);
        mask = m;
        repeat (SCAN * n) @(negedge clk);
    endtask

    int c0, p0;

    initial begin
        // 1: reset, column walk, then a 3-clock reset mid-scan and a walk again.
        reset_dut();
        col_walk();
        run_scans(16'h0, 1);
        repeat (6) @(negedge clk);
        reset_dut();
        col_walk();
        run_scans(16'h0, 1);

        // 2: key 5 held 5 scans.
        c0 = cyc; p0 = pulse_cnt;
        run_scans(K5, 5);
        check("t2 pulses", 32'(pulse_cnt - p0), 32'd1);
        check("t2 key", 32'(last_pulse_key), 32'h5);
        check("t2 latency", 32'(last_pulse_cyc - c0), 32'd49);
        check("t2 held", 32'(key_held_o), 32'd1);
        run_scans(16'h0, 4);

        // 3: key D bounces, absent for scan 3.
        c0 = cyc; p0 = pulse_cnt;
        run_scans(KD, 2);
        run_scans(16'h0, 1);
        run_scans(KD, 3);
        check("t3 no early pulse", 32'(pulse_cnt - p0), 32'd0);
        @(negedge clk);
        check("t3 pulses", 32'(pulse_cnt - p0), 32'd1);
        check("t3 key", 32'(key_o), 32'hD);
        check("t3 latency", 32'(last_pulse_cyc - c0), 32'd97);
        repeat (SCAN - 1) @(negedge clk);
        run_scans(16'h0, 4);

        // 4: A held, short release, re-press, then full release.
        p0 = pulse_cnt;
        run_scans(KA, 4);
        run_scans(16'h0, 2);
        run_scans(KA, 3);
        check("t4 pulses", 32'(pulse_cnt - p0), 32'd1);
        check("t4 held", 32'(key_held_o), 32'd1);
        run_scans(16'h0, 3);
        check("t4 held at rel end", 32'(key_held_o), 32'd1);
        @(negedge clk);
        check("t4 released", 32'(key_held_o), 32'd0);
        check("t4 key kept", 32'(key_o), 32'hA);
        repeat (SCAN - 1) @(negedge clk);

        // 5: 1 and 9 together, then 9 alone.
        p0 = pulse_cnt;
        run_scans(K1 | K9, 4);
        check("t5 multi pulses", 32'(pulse_cnt - p0), 32'd0);
        check("t5 multi held", 32'(key_held_o), 32'd0);
        run_scans(K9, 4);
        check("t5 pulses", 32'(pulse_cnt - p0), 32'd1);
        check("t5 key", 32'(key_o), 32'h9);
        run_scans(16'h0, 4);

        // 6: 7 for 2 scans, then 8.
        c0 = cyc; p0 = pulse_cnt;
        run_scans(K7, 2);
        run_scans(K8, 4);
        check("t6 pulses", 32'(pulse_cnt - p0), 32'd1);
        check("t6 key", 32'(key_o), 32'h8);
        check("t6 latency", 32'(last_pulse_cyc - c0), 32'd81);
        check("t6 never 7", 32'(saw7), 32'd0);
        run_scans(16'h0, 4);

        // Mid-scan reset after a key was accepted clears key_o.
        repeat (5) @(negedge clk);
        reset_dut();
        repeat (8) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
